// File: rtl/dino_pkg.sv
// Shared definitions for the dinosaur runner: game state encodings and bus widths.
// Used by the game controller, Ground, Jump and the VGA score renderer.
package dino_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUNNING = 2'd1,
    ST_CRASHED = 2'd2,
    ST_UNUSED  = 2'd3
  } game_state_t;

  localparam int SPEED_W      = 4;
  localparam int SCORE_DIGITS = 4;
  localparam int SCORE_W      = 4 * SCORE_DIGITS;

endpackage

// File: rtl/frame_tick_gen.sv
// Free-running frame divider: a registered one-cycle pulse every TICK_DIV clocks.
module frame_tick_gen #(
  parameter int TICK_DIV = 1_000_000
) (
  input  logic CLK,
  input  logic RST,
  output logic tick
);

  localparam int W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

  logic [W-1:0] cnt;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      cnt  <= '0;
      tick <= 1'b0;
    end else begin
      tick <= (cnt == LAST);
      cnt  <= (cnt == LAST) ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/game_controller.sv
// Game sequencer: idle/running/crashed FSM, speed ramp and saturating BCD score.
// Every output is registered; collision beats a coincident frame tick.
module game_controller
  import dino_pkg::*;
#(
  parameter int TICK_DIV          = 1_000_000,
  parameter int SPEED_STEP_FRAMES = 500,
  parameter int SPEED_MAX         = 15,
  parameter int RESTART_HOLDOFF   = 50
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               btn_jump,
  input  logic               collision,
  output logic               game_status,
  output logic [SPEED_W-1:0] speed,
  output logic [SCORE_W-1:0] score,
  output logic               frame_tick,
  output logic [1:0]         state
);

  localparam int FW = $clog2(SPEED_STEP_FRAMES + 1);
  localparam int HW = $clog2(RESTART_HOLDOFF + 1);
  localparam logic [FW-1:0]      FRAME_LAST = FW'(SPEED_STEP_FRAMES - 1);
  localparam logic [HW-1:0]      HOLD_MAX   = HW'(RESTART_HOLDOFF);
  localparam logic [SPEED_W-1:0] SPD_MAX    = SPEED_W'(SPEED_MAX);

  game_state_t       st;
  logic              btn_q;
  logic              jump_edge;
  logic [FW-1:0]     frame_cnt;
  logic [HW-1:0]     hold_cnt;

  function automatic logic [SCORE_W-1:0] bcd_inc(input logic [SCORE_W-1:0] v);
    logic [SCORE_W-1:0] r;
    logic               carry;
    r     = v;
    carry = 1'b1;
    if (v == {SCORE_DIGITS{4'h9}}) return v;
    for (int i = 0; i < SCORE_DIGITS; i++) begin
      if (carry) begin
        if (r[i*4 +: 4] == 4'd9) begin
          r[i*4 +: 4] = 4'd0;
        end else begin
          r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  frame_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .CLK  (CLK),
    .RST  (RST),
    .tick (frame_tick)
  );

  assign jump_edge = btn_jump & ~btn_q;
  assign state     = st;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      st          <= ST_IDLE;
      btn_q       <= 1'b0;
      game_status <= 1'b0;
      speed       <= '0;
      score       <= '0;
      frame_cnt   <= '0;
      hold_cnt    <= '0;
    end else begin
      btn_q <= btn_jump;
      case (st)
        ST_IDLE: begin
          game_status <= 1'b0;
          if (jump_edge) begin
            st          <= ST_RUNNING;
            game_status <= 1'b1;
            score       <= '0;
            speed       <= SPEED_W'(1);
            frame_cnt   <= '0;
          end
        end
        ST_RUNNING: begin
          game_status <= 1'b1;
          if (collision) begin
            st          <= ST_CRASHED;
            game_status <= 1'b0;
            hold_cnt    <= '0;
          end else if (frame_tick) begin
            score <= bcd_inc(score);
            if (frame_cnt == FRAME_LAST) begin
              frame_cnt <= '0;
              if (speed < SPD_MAX) speed <= speed + 1'b1;
            end else begin
              frame_cnt <= frame_cnt + 1'b1;
            end
          end
        end
        ST_CRASHED: begin
          game_status <= 1'b0;
          if (frame_tick && hold_cnt < HOLD_MAX) hold_cnt <= hold_cnt + 1'b1;
          // Restart decision uses the holdoff count before this edge's tick.
          if (jump_edge && hold_cnt == HOLD_MAX) begin
            st          <= ST_RUNNING;
            game_status <= 1'b1;
            score       <= '0;
            speed       <= SPEED_W'(1);
            frame_cnt   <= '0;
          end
        end
        default: begin
          st          <= ST_IDLE;
          game_status <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_game_controller.sv
// Directed bench for game_controller with small timing parameters.
module tb_game_controller;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        btn_jump = 1'b0;
  logic        collision = 1'b0;
  logic        game_status;
  logic [3:0]  speed;
  logic [15:0] score;
  logic        frame_tick;
  logic [1:0]  state;

  int checks = 0;
  int errors = 0;

  game_controller #(
    .TICK_DIV(4), .SPEED_STEP_FRAMES(3), .SPEED_MAX(3), .RESTART_HOLDOFF(2)
  ) dut (
    .CLK(CLK), .RST(RST), .btn_jump(btn_jump), .collision(collision),
    .game_status(game_status), .speed(speed), .score(score),
    .frame_tick(frame_tick), .state(state)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Lets n frame ticks be consumed by the DUT; returns just after the last one.
  task automatic apply_ticks(input int n);
    int budget;
    for (int k = 0; k < n; k++) begin
      budget = 0;
      while (!frame_tick && budget < 8) begin
        step();
        budget++;
      end
      if (!frame_tick) begin
        check("tick_timeout", 0, 1);
        return;
      end
      step();
    end
  endtask

  task automatic press();
    btn_jump = 1'b1;
    step();
    btn_jump = 1'b0;
    step();
  endtask

  initial begin
    int pulses;
    #2;
    check("rst_state", state, 0);
    check("rst_status", game_status, 0);
    check("rst_speed", speed, 0);
    check("rst_score", score, 0);
    check("rst_tick", frame_tick, 0);
    step(); step();
    RST = 1'b0;

    pulses = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (frame_tick) pulses++;
    end
    check("idle_pulses", pulses, 10);
    check("idle_state", state, 0);
    check("idle_status", game_status, 0);
    check("idle_speed", speed, 0);
    check("idle_score", score, 0);

    btn_jump = 1'b1;
    #1;
    check("no_comb_path", game_status, 0);
    step();
    check("press_state", state, 1);
    check("press_status", game_status, 1);
    check("press_speed", speed, 1);
    check("press_score", score, 0);

    apply_ticks(12);
    check("run12_score", score, 16'h0012);
    check("run12_speed", speed, 3);
    check("run12_state", state, 1);

    apply_ticks(9999 - 12);
    check("sat_score", score, 16'h9999);
    apply_ticks(3);
    check("sat_hold", score, 16'h9999);
    check("sat_speed", speed, 3);
    btn_jump = 1'b0;
    step();

    collision = 1'b1;
    step();
    collision = 1'b0;
    check("crash_state", state, 2);
    check("crash_status", game_status, 0);
    check("crash_score", score, 16'h9999);

    apply_ticks(1);
    press();
    check("holdoff_ignore", state, 2);
    apply_ticks(1);
    press();
    check("restart_state", state, 1);
    check("restart_score", score, 0);
    check("restart_speed", speed, 1);

    apply_ticks(5);
    check("pre_coll_score", score, 16'h0005);
    begin
      int budget = 0;
      while (!frame_tick && budget < 8) begin
        step();
        budget++;
      end
      check("coll_tick_seen", frame_tick, 1);
    end
    collision = 1'b1;
    step();
    collision = 1'b0;
    check("coll_tick_state", state, 2);
    check("coll_tick_status", game_status, 0);
    check("coll_tick_score", score, 16'h0005);
    check("coll_tick_speed", speed, 2);

    apply_ticks(2);
    press();
    check("rerun_state", state, 1);
    apply_ticks(4);
    check("mid_score", score, 16'h0004);
    check("mid_speed", speed, 2);
    RST = 1'b1;
    #2;
    check("async_state", state, 0);
    check("async_status", game_status, 0);
    check("async_speed", speed, 0);
    check("async_score", score, 0);
    check("async_tick", frame_tick, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
